seq_detect_sched: RTL and testbench

//   Shares one serial pattern-detector engine among N requesters.
//   - Arbitrates pending words round-robin and serialises the granted word MSB-first.
//   - Counts overlapping pattern matches within that word and returns the count tagged with the requester id.
//   - Holds the programmable pattern/length configuration for the engine.

---
 rtl/seq_detect_pkg.sv | 33 +++
 rtl/seq_detect_sched_pattern_engine.sv | 69 ++++++
 rtl/seq_detect_sched.sv | 140 ++++++++++++++
 tb/tb_seq_detect_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern-detector scheduler:
// FSM state encoding, power-up detector configuration, round-robin pick.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         DEF_LEN     = 3;
  localparam logic [3:0] DEF_PATTERN = 4'b0101;
  localparam int         RR_MAX      = 64;

  // Index of the first set bit at or after ptr, wrapping modulo n.
  function automatic int rr_next(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int   pick;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (ptr + i) % n;
      if (!found && req[idx[5:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seq_detect_sched_pattern_engine.sv
// Serial overlapping pattern matcher: shifts one bit per enabled cycle into a
// window and flags when the newest cfg_len bits equal the configured pattern.
module pattern_engine #(
  parameter int W     = 8,
  parameter int PAT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         shift_en,
  input  logic                         x,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  output logic                         match,
  output logic                         detected,
  output logic [$clog2(W+1)-1:0]       bit_cnt
);

  localparam int CW = $clog2(W + 1);
  localparam int LW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] window_q, window_d, window_next, mask;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d, seen_next;
  logic             detected_q, detected_d;

  assign window_next = {window_q[PAT_W-2:0], x};
  assign seen_next   = bit_cnt_q + 1'b1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LW'(i) < cfg_len);
    end
  end

  // A match needs at least cfg_len bits of the current word in the window.
  assign match = shift_en && (int'(seen_next) >= int'(cfg_len)) &&
                 ((window_next & mask) == (cfg_pattern & mask));

  always_comb begin
    window_d   = window_q;
    bit_cnt_d  = bit_cnt_q;
    detected_d = 1'b0;
    if (clear) begin
      window_d  = '0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      window_d   = window_next;
      bit_cnt_d  = seen_next;
      detected_d = match;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q   <= '0;
      bit_cnt_q  <= '0;
      detected_q <= 1'b0;
    end else begin
      window_q   <= window_d;
      bit_cnt_q  <= bit_cnt_d;
      detected_q <= detected_d;
    end
  end

  assign detected = detected_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial pattern engine among N requesters;
// returns the per-word match count tagged with the requester id.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int PAT_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               req,
  input  logic [N*W-1:0]             data,
  output logic [N-1:0]               gnt,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  output logic                       busy,
  output logic                       x,
  output logic                       detected,
  output logic                       res_valid,
  output logic [$clog2(N)-1:0]       res_id,
  output logic [$clog2(W+1)-1:0]     res_count
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(W + 1);
  localparam int LW  = $clog2(PAT_W + 1);

  state_t           state_q, state_d;
  logic [W-1:0]     word_q, word_d;
  logic [IDW-1:0]   id_q, id_d, rr_ptr_q, rr_ptr_d, pick;
  logic [PAT_W-1:0] cfg_pattern_q, cfg_pattern_d;
  logic [LW-1:0]    cfg_len_q, cfg_len_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             res_valid_q, res_valid_d;
  logic [CW-1:0]    res_count_q, res_count_d;
  logic             cfg_ok, shift_en, clear, match;
  logic [CW-1:0]    bit_cnt;
  logic [W-1:0]     words [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign words[gi] = data[gi*W +: W];
  end

  assign pick     = IDW'(rr_next(RR_MAX'(req), int'(rr_ptr_q), N));
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(PAT_W));
  assign shift_en = (state_q == SHIFT);
  assign clear    = (state_q == LOAD);

  pattern_engine #(.W(W), .PAT_W(PAT_W)) u_engine (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (clear),
    .shift_en   (shift_en),
    .x          (x),
    .cfg_pattern(cfg_pattern_q),
    .cfg_len    (cfg_len_q),
    .match      (match),
    .detected   (detected),
    .bit_cnt    (bit_cnt)
  );

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    id_d          = id_q;
    rr_ptr_d      = rr_ptr_q;
    cfg_pattern_d = cfg_pattern_q;
    cfg_len_d     = cfg_len_q;
    gnt_d         = '0;
    res_valid_d   = 1'b0;
    res_count_d   = res_count_q;
    case (state_q)
      IDLE: begin
        // A config write takes the whole IDLE cycle; arbitration waits.
        if (cfg_we) begin
          if (cfg_ok) begin
            cfg_pattern_d = cfg_pattern;
            cfg_len_d     = cfg_len;
          end
        end else if (|req) begin
          id_d        = pick;
          word_d      = words[pick];
          gnt_d[pick] = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        res_count_d = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        word_d = {word_q[W-2:0], 1'b0};
        if (match) res_count_d = res_count_q + 1'b1;
        if (bit_cnt == CW'(W - 1)) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
        end
      end
      DONE: begin
        rr_ptr_d = id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      word_q        <= '0;
      id_q          <= '0;
      rr_ptr_q      <= '0;
      cfg_pattern_q <= PAT_W'(DEF_PATTERN);
      cfg_len_q     <= LW'(DEF_LEN);
      gnt_q         <= '0;
      res_valid_q   <= 1'b0;
      res_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      id_q          <= id_d;
      rr_ptr_q      <= rr_ptr_d;
      cfg_pattern_q <= cfg_pattern_d;
      cfg_len_q     <= cfg_len_d;
      gnt_q         <= gnt_d;
      res_valid_q   <= res_valid_d;
      res_count_q   <= res_count_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign x         = shift_en ? word_q[W-1] : 1'b0;
  assign res_valid = res_valid_q;
  assign res_id    = id_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: a job-timeline model predicts every output per
// cycle, plus literal expectations for the directed scenarios.
module tb_seq_detect_sched;

  localparam int N = 4, W = 8, PAT_W = 4, MAXC = 2000;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic           cfg_we = 1'b0;
  logic [3:0]     cfg_pattern = '0;
  logic [2:0]     cfg_len = '0;
  logic [N-1:0]   gnt;
  logic           busy, x, detected, res_valid;
  logic [1:0]     res_id;
  logic [3:0]     res_count;

  seq_detect_sched #(.N(N), .W(W), .PAT_W(PAT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .busy(busy), .x(x), .detected(detected), .res_valid(res_valid),
    .res_id(res_id), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected-output timeline, indexed by cycle number.
  bit [N-1:0] e_gnt [MAXC];
  bit         e_busy[MAXC], e_x[MAXC], e_det[MAXC], e_rv[MAXC];
  int         e_id[MAXC], e_cnt[MAXC];
  int         cyc = 0, m_free = 0, m_rr = 0, m_len = 3;
  bit [3:0]   m_pat = 4'b0101;
  int         m_res_q[$], det_q[$];

  // Job whose request is seen in idle cycle t: grant t+1, bits t+2..t+1+W, result t+2+W.
  task automatic schedule(input int t);
    int id, cnt;
    bit [W-1:0] w;
    bit hit;
    id = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (id < 0 && req[k]) id = k;
    end
    w = data[id*W +: W];
    e_gnt[t+1] = '0;
    e_gnt[t+1][id] = 1'b1;
    for (int c = t + 1; c <= t + 2 + W; c++) e_busy[c] = 1'b1;
    cnt = 0;
    for (int k = 0; k < W; k++) begin
      e_x[t+2+k] = w[W-1-k];
      if (k + 1 >= m_len) begin
        hit = 1'b1;
        for (int j = 0; j < m_len; j++)
          if (w[W-1-(k-j)] != m_pat[j]) hit = 1'b0;
        if (hit) begin
          e_det[t+3+k] = 1'b1;
          cnt++;
        end
      end
    end
    e_rv[t+2+W]  = 1'b1;
    e_id[t+2+W]  = id;
    e_cnt[t+2+W] = cnt;
    m_rr   = (id + 1) % N;
    m_free = t + 3 + W;
    m_res_q.push_back(cnt);
  endtask

  always @(posedge clk) begin
    if (cyc < MAXC - 20) begin
      if (!reset) begin
        for (int i = cyc + 1; i < MAXC; i++) begin
          e_gnt[i] = '0; e_busy[i] = 0; e_x[i] = 0; e_det[i] = 0; e_rv[i] = 0;
          e_id[i] = 0; e_cnt[i] = 0;
        end
        m_free = cyc + 1;
        m_rr   = 0;
        m_pat  = 4'b0101;
        m_len  = 3;
      end else if (cyc >= m_free) begin
        if (cfg_we) begin
          if (int'(cfg_len) >= 1 && int'(cfg_len) <= PAT_W) begin
            m_pat = cfg_pattern;
            m_len = int'(cfg_len);
          end
        end else if (|req) begin
          schedule(cyc);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (!reset) begin
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_detected", int'(detected), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_count", int'(res_count), 0);
      end else begin
        chk("gnt", int'(gnt), int'(e_gnt[cyc]));
        chk("busy", int'(busy), int'(e_busy[cyc]));
        chk("x", int'(x), int'(e_x[cyc]));
        chk("detected", int'(detected), int'(e_det[cyc]));
        chk("res_valid", int'(res_valid), int'(e_rv[cyc]));
        if (e_rv[cyc]) begin
          chk("res_id", int'(res_id), e_id[cyc]);
          chk("res_count", int'(res_count), e_cnt[cyc]);
        end
        if (detected) det_q.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input bit [3:0] p, input int l);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = 3'(l);
    step(1);
    cfg_we = 1'b0;
    step(1);
  endtask

  // mode 0: plain job; 1: config write in the request cycle; 2: config write mid-job.
  task automatic run_job(input int id, input bit [7:0] w, input int mode, input bit [3:0] cp,
                         input int cl, output int s, output int g, output int r,
                         output int rid, output int rcnt);
    data[id*W +: W] = w;
    req[id] = 1'b1;
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_pattern = cp; cfg_len = 3'(cl);
    end
    s = cyc; g = -1; r = -1; rid = -1; rcnt = -1;
    for (int i = 0; i < 30 && g < 0; i++) begin
      step(1);
      cfg_we = 1'b0;
      if (gnt[id]) begin
        g = cyc;
        req[id] = 1'b0;
      end
    end
    req[id] = 1'b0;
    chk("gnt_seen", int'(g >= 0), 1);
    if (mode == 2) begin
      step(2);
      cfg_we = 1'b1; cfg_pattern = cp; cfg_len = 3'(cl);
      step(1);
      cfg_we = 1'b0;
    end
    for (int i = 0; i < 30 && r < 0; i++) begin
      if (res_valid) begin
        r = cyc; rid = int'(res_id); rcnt = int'(res_count);
      end else step(1);
    end
    chk("res_seen", int'(r >= 0), 1);
    step(1);
  endtask

  task automatic run_multi(input bit [3:0] mask, output int ord[4], output int nord);
    req = mask;
    nord = 0;
    ord = '{-1, -1, -1, -1};
    for (int i = 0; i < 200 && req != 0; i++) begin
      step(1);
      if (gnt != 0) begin
        for (int k = 0; k < N; k++)
          if (gnt[k]) begin
            if (nord < 4) ord[nord] = k;
            nord++;
          end
        req = req & ~gnt;
      end
    end
    chk("multi_drained", int'(req), 0);
    for (int i = 0; i < 30 && busy; i++) step(1);
    chk("multi_idle", int'(busy), 0);
    step(1);
  endtask

  initial begin
    int s, g, r, rid, rcnt, nord, rv_seen;
    int ord[4];
    step(3);
    reset = 1'b1;
    step(2);

    // Reset in the middle of a shifting job
    data[0 +: W] = 8'hA5;
    req[0] = 1'b1;
    g = -1;
    for (int i = 0; i < 10 && g < 0; i++) begin
      step(1);
      if (gnt[0]) g = cyc;
    end
    req[0] = 1'b0;
    chk("t1_gnt_seen", int'(g >= 0), 1);
    step(4);
    chk("t1_busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t1_busy", int'(busy), 0);
    chk("t1_x", int'(x), 0);
    chk("t1_res_count", int'(res_count), 0);
    step(1);
    reset = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (res_valid) rv_seen++;
    end
    chk("t1_no_result", rv_seen, 0);

    // Round-robin order, then wrap
    data = {8'h3C, 8'h0F, 8'hA5, 8'h5A};
    run_multi(4'b1111, ord, nord);
    chk("t3_n", nord, 4);
    chk("t3_o0", ord[0], 0);
    chk("t3_o1", ord[1], 1);
    chk("t3_o2", ord[2], 2);
    chk("t3_o3", ord[3], 3);
    run_multi(4'b1001, ord, nord);
    chk("t3b_n", nord, 2);
    chk("t3b_o0", ord[0], 0);
    chk("t3b_o1", ord[1], 3);

    // Default 101 detector
    run_job(0, 8'b1010_1010, 0, 4'b0, 0, s, g, r, rid, rcnt);
    chk("t2_gnt_lat", g - s, 1);
    chk("t2_res_lat", r - s, 10);
    chk("t2_id", rid, 0);
    chk("t2_count", rcnt, 3);
    chk("t2_model_count", m_res_q[$], 3);

    // Length-4 pattern 1101
    cfg_write(4'b1101, 4);
    det_q.delete();
    run_job(1, 8'b1101_1011, 0, 4'b0, 0, s, g, r, rid, rcnt);
    chk("t4_count", rcnt, 2);
    chk("t4_id", rid, 1);
    chk("t4_model_count", m_res_q[$], 2);
    chk("t4_det_n", det_q.size(), 2);
    chk("t4_det0", (det_q.size() > 0) ? det_q[0] - g : -1, 5);
    chk("t4_det1", (det_q.size() > 1) ? det_q[1] - g : -1, 8);

    // Single-bit pattern; config write during SHIFT must not take effect
    cfg_write(4'b0001, 1);
    run_job(0, 8'hFF, 2, 4'b0000, 1, s, g, r, rid, rcnt);
    chk("t5_ff", rcnt, 8);
    run_job(1, 8'h00, 0, 4'b0, 0, s, g, r, rid, rcnt);
    chk("t5_00", rcnt, 0);

    // Config write and request in the same idle cycle
    run_job(2, 8'b0111_0110, 1, 4'b0011, 2, s, g, r, rid, rcnt);
    chk("t6_gnt_lat", g - s, 2);
    chk("t6_id", rid, 2);
    chk("t6_count", rcnt, 3);
    cfg_write(4'b0000, 0);
    run_job(2, 8'b0111_0110, 0, 4'b0, 0, s, g, r, rid, rcnt);
    chk("t6_len0_ignored", rcnt, 3);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
